fwd_hazard_sb: RTL and testbench

- Parametrised forwarding and hazard unit for operands read in ID, such as branch compare and FMA rs3.
- Serves NUM_SRC source ports over the combined int/fp register space.
- Selects forwarding sources among EX, MEM and WB, and detects load-use hazards.
- Holds a registered scoreboard of outstanding long-latency writes (FPU div/sqrt, MUL/DIV). Asserts a single stall to ID and issue control.

---
 rtl/fwd_hazard_sb_if.sv | 47 ++++
 rtl/fwd_hazard_sb.sv | 116 +++++++++++
 tb/tb_fwd_hazard_sb.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_sb_if.sv
// Bundle of ID source, issue, pipeline-stage and long-unit signals for fwd_hazard_sb.
// The core drives through the master modport; the unit consumes through slave.
interface fwd_hazard_sb_if #(
    parameter int NUM_SRC = 3,
    parameter int REG_AW  = 5
);
    logic [NUM_SRC*REG_AW-1:0] id_rs_addr;
    logic [NUM_SRC-1:0]        id_rs_fp;
    logic [NUM_SRC-1:0]        id_rs_used;

    logic                      iss_valid;
    logic [REG_AW-1:0]         iss_rd;
    logic                      iss_rd_fp;
    logic                      iss_wb;
    logic                      iss_long;

    logic [REG_AW-1:0]         ex_rd, mem_rd, wb_rd;
    logic                      ex_fp, mem_fp, wb_fp;
    logic                      ex_wb, mem_wb, wb_wb;
    logic                      ex_memr, mem_memr;

    logic                      lu_done;
    logic [REG_AW-1:0]         lu_rd;
    logic                      lu_fp;

    logic [NUM_SRC*3-1:0]      fwd_sel;
    logic                      hz_stall;
    logic                      sb_full;

    modport master (
        output id_rs_addr, id_rs_fp, id_rs_used,
        output iss_valid, iss_rd, iss_rd_fp, iss_wb, iss_long,
        output ex_rd, mem_rd, wb_rd, ex_fp, mem_fp, wb_fp,
        output ex_wb, mem_wb, wb_wb, ex_memr, mem_memr,
        output lu_done, lu_rd, lu_fp,
        input  fwd_sel, hz_stall, sb_full
    );

    modport slave (
        input  id_rs_addr, id_rs_fp, id_rs_used,
        input  iss_valid, iss_rd, iss_rd_fp, iss_wb, iss_long,
        input  ex_rd, mem_rd, wb_rd, ex_fp, mem_fp, wb_fp,
        input  ex_wb, mem_wb, wb_wb, ex_memr, mem_memr,
        input  lu_done, lu_rd, lu_fp,
        output fwd_sel, hz_stall, sb_full
    );
endinterface

// File: rtl/fwd_hazard_sb.sv
// ID-stage forwarding select, load-use detection and long-latency write scoreboard.
// Optional FWD_PERF_CNT_EN adds saturating stall/forward-hit performance counters.
module fwd_hazard_sb #(
    parameter int NUM_SRC = 3,
    parameter int REG_AW  = 5,
    parameter int MAX_OUT = 4,
    parameter int OUT_W   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    fwd_hazard_sb_if.slave bus
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [15:0]    perf_lu_stall,
    output logic [15:0]    perf_sb_stall,
    output logic [15:0]    perf_fwd_hits
`endif
);
    localparam int NENT = 2 ** (REG_AW + 1);

    logic [NENT-1:0]      pend_q, pend_d;
    logic [OUT_W-1:0]     cnt_q, cnt_d;
    logic                 full_q, full_d;

    logic [NUM_SRC-1:0]   ex_hit, mem_hit, wb_hit, pend_hit;
    logic [NUM_SRC*3-1:0] fwd_sel_c;
    logic                 cause_a, cause_b, cause_c, cause_d, stall_c;
    logic                 set_en, clr_en;

    // Integer x0 is hardwired zero and never forwards; fp f0 is a real register.
    function automatic logic stage_hit(input logic wb, input logic [REG_AW-1:0] rd,
                                       input logic fp, input logic [REG_AW-1:0] addr,
                                       input logic sfp, input logic used);
        return wb && used && (rd == addr) && (fp == sfp) && (fp || (rd != '0));
    endfunction

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_AW-1:0] addr;
        logic              sfp, used;
        logic [2:0]        sel;

        assign addr        = bus.id_rs_addr[g*REG_AW +: REG_AW];
        assign sfp         = bus.id_rs_fp[g];
        assign used        = bus.id_rs_used[g];
        assign ex_hit[g]   = stage_hit(bus.ex_wb,  bus.ex_rd,  bus.ex_fp,  addr, sfp, used);
        assign mem_hit[g]  = stage_hit(bus.mem_wb, bus.mem_rd, bus.mem_fp, addr, sfp, used);
        assign wb_hit[g]   = stage_hit(bus.wb_wb,  bus.wb_rd,  bus.wb_fp,  addr, sfp, used);
        assign pend_hit[g] = used && pend_q[{sfp, addr}];

        always_comb begin
            sel = 3'b000;
            if (ex_hit[g])       sel = 3'b001;
            else if (mem_hit[g]) sel = bus.mem_memr ? 3'b011 : 3'b010;
            else if (wb_hit[g])  sel = 3'b100;
        end

        assign fwd_sel_c[g*3 +: 3] = sel;
    end

    assign cause_a = bus.ex_memr && (|ex_hit);
    assign cause_b = |pend_hit;
    assign cause_c = bus.iss_wb && bus.iss_long && full_q;
    assign cause_d = bus.iss_wb && pend_q[{bus.iss_rd_fp, bus.iss_rd}];
    assign stall_c = cause_a || cause_b || cause_c || cause_d;

    // A same-entry set/clear cannot coincide: the WAW stall blocks that set.
    always_comb begin
        set_en = bus.iss_valid && !stall_c && bus.iss_wb && bus.iss_long
                 && (bus.iss_rd_fp || (bus.iss_rd != '0));
        clr_en = bus.lu_done && pend_q[{bus.lu_fp, bus.lu_rd}];
        pend_d = pend_q;
        if (clr_en) pend_d[{bus.lu_fp, bus.lu_rd}] = 1'b0;
        if (set_en) pend_d[{bus.iss_rd_fp, bus.iss_rd}] = 1'b1;
        cnt_d  = cnt_q + OUT_W'(set_en) - OUT_W'(clr_en);
        full_d = (cnt_d == OUT_W'(MAX_OUT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign bus.fwd_sel  = fwd_sel_c;
    assign bus.hz_stall = stall_c;
    assign bus.sb_full  = full_q;

`ifdef FWD_PERF_CNT_EN
    logic [15:0] perf_lu_q, perf_sb_q, perf_fwd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q  <= '0;
            perf_sb_q  <= '0;
            perf_fwd_q <= '0;
        end else begin
            if (cause_a && perf_lu_q != 16'hFFFF)
                perf_lu_q <= perf_lu_q + 16'd1;
            if ((cause_b || cause_c || cause_d) && perf_sb_q != 16'hFFFF)
                perf_sb_q <= perf_sb_q + 16'd1;
            if ((|fwd_sel_c) && perf_fwd_q != 16'hFFFF)
                perf_fwd_q <= perf_fwd_q + 16'd1;
        end
    end

    assign perf_lu_stall = perf_lu_q;
    assign perf_sb_stall = perf_sb_q;
    assign perf_fwd_hits = perf_fwd_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_sb.sv
// Directed bench for fwd_hazard_sb: forwarding priority, load-use, x0/f0, scoreboard RAW/full/WAW, reset.
module tb_fwd_hazard_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fwd_hazard_sb_if #(.NUM_SRC(3), .REG_AW(5)) bus();

`ifdef FWD_PERF_CNT_EN
    logic [15:0] perf_lu_stall, perf_sb_stall, perf_fwd_hits;
`endif

    fwd_hazard_sb #(.NUM_SRC(3), .REG_AW(5), .MAX_OUT(4), .OUT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef FWD_PERF_CNT_EN
        ,
        .perf_lu_stall (perf_lu_stall),
        .perf_sb_stall (perf_sb_stall),
        .perf_fwd_hits (perf_fwd_hits)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        bus.id_rs_addr = '0; bus.id_rs_fp = '0; bus.id_rs_used = '0;
        bus.iss_valid = 0; bus.iss_rd = '0; bus.iss_rd_fp = 0; bus.iss_wb = 0; bus.iss_long = 0;
        bus.ex_rd = '0; bus.mem_rd = '0; bus.wb_rd = '0;
        bus.ex_fp = 0; bus.mem_fp = 0; bus.wb_fp = 0;
        bus.ex_wb = 0; bus.mem_wb = 0; bus.wb_wb = 0;
        bus.ex_memr = 0; bus.mem_memr = 0;
        bus.lu_done = 0; bus.lu_rd = '0; bus.lu_fp = 0;
    endtask

    task automatic src(input int i, input logic [4:0] a, input logic fp);
        bus.id_rs_addr[i*5 +: 5] = a;
        bus.id_rs_fp[i]   = fp;
        bus.id_rs_used[i] = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic fp, input logic lng);
        bus.iss_valid = 1; bus.iss_wb = 1; bus.iss_rd = rd; bus.iss_rd_fp = fp; bus.iss_long = lng;
    endtask

    task automatic done(input logic [4:0] rd, input logic fp);
        bus.lu_done = 1; bus.lu_rd = rd; bus.lu_fp = fp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_in();
        #2;
        check("rst_fwd", 16'(bus.fwd_sel), 16'h000);
        check("rst_stall", 16'(bus.hz_stall), 16'h0);
        check("rst_full", 16'(bus.sb_full), 16'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // EX forward, then priority over MEM/WB, then MEM and WB alone
        bus.ex_wb = 1; bus.ex_rd = 5; src(0, 5, 0);
        #1 check("ex_fwd", 16'(bus.fwd_sel), 16'h001);
        check("ex_fwd_stall", 16'(bus.hz_stall), 16'h0);
        bus.mem_wb = 1; bus.mem_rd = 5; bus.wb_wb = 1; bus.wb_rd = 5;
        #1 check("ex_prio", 16'(bus.fwd_sel), 16'h001);
        bus.ex_wb = 0;
        #1 check("mem_alu", 16'(bus.fwd_sel), 16'h002);
        bus.mem_wb = 0;
        #1 check("wb_fwd", 16'(bus.fwd_sel), 16'h004);
        bus.wb_fp = 1;
        #1 check("bank_miss", 16'(bus.fwd_sel), 16'h000);

        // Load-use on src1, then load data forwarded from MEM
        clr_in();
        bus.ex_wb = 1; bus.ex_memr = 1; bus.ex_rd = 7; src(1, 7, 0);
        #1 check("lu_stall", 16'(bus.hz_stall), 16'h1);
        check("lu_fwd", 16'(bus.fwd_sel), 16'h008);
        tick();
        clr_in();
        bus.mem_wb = 1; bus.mem_memr = 1; bus.mem_rd = 7; src(1, 7, 0);
        #1 check("mem_load", 16'(bus.fwd_sel), 16'h018);
        check("mem_load_stall", 16'(bus.hz_stall), 16'h0);

        // x0 never matches, f0 does
        clr_in();
        bus.ex_wb = 1; bus.ex_rd = 0; bus.ex_memr = 1; src(0, 0, 0);
        #1 check("x0_fwd", 16'(bus.fwd_sel), 16'h000);
        check("x0_no_lu", 16'(bus.hz_stall), 16'h0);
        bus.ex_memr = 0; bus.ex_fp = 1; bus.id_rs_fp[0] = 1;
        #1 check("f0_fwd", 16'(bus.fwd_sel), 16'h001);

        // Long RAW on f3 via src2
        clr_in();
        issue(3, 1, 1);
        #1 check("iss_f3_ok", 16'(bus.hz_stall), 16'h0);
        tick();
        clr_in();
        src(2, 3, 1);
        #1 check("raw_stall0", 16'(bus.hz_stall), 16'h1);
        tick();
        check("raw_stall1", 16'(bus.hz_stall), 16'h1);
        done(3, 1);
        #1 check("raw_stall_done", 16'(bus.hz_stall), 16'h1);
        tick();
        bus.lu_done = 0;
        bus.wb_wb = 1; bus.wb_rd = 3; bus.wb_fp = 1;
        #1 check("raw_wb_fwd", 16'(bus.fwd_sel), 16'h100);
        check("raw_released", 16'(bus.hz_stall), 16'h0);

        // Spurious completion must not underflow the count
        clr_in();
        done(20, 0);
        tick();
        clr_in();
        check("spur_full", 16'(bus.sb_full), 16'h0);

        // Fill the scoreboard with x1..x4
        for (int r = 1; r <= 4; r++) begin
            clr_in();
            issue(5'(r), 0, 1);
            #1 check("fill_nostall", 16'(bus.hz_stall), 16'h0);
            tick();
        end
        clr_in();
        check("full_set", 16'(bus.sb_full), 16'h1);
        issue(5, 0, 1);
        #1 check("full_stall", 16'(bus.hz_stall), 16'h1);
        tick();
        check("full_hold", 16'(bus.sb_full), 16'h1);
        done(2, 0);
        #1 check("full_stall_done", 16'(bus.hz_stall), 16'h1);
        tick();
        bus.lu_done = 0;
        check("full_clear", 16'(bus.sb_full), 16'h0);
        check("full_issue_go", 16'(bus.hz_stall), 16'h0);
        tick();
        clr_in();
        check("full_again", 16'(bus.sb_full), 16'h1);
        src(0, 5, 0);
        #1 check("x5_pending", 16'(bus.hz_stall), 16'h1);
        src(0, 2, 0);
        #1 check("x2_cleared", 16'(bus.hz_stall), 16'h0);

        // Simultaneous set and clear keeps the count (3 -> 3), then set to 4
        clr_in();
        done(3, 0);
        tick();
        clr_in();
        check("cnt3_full", 16'(bus.sb_full), 16'h0);
        issue(6, 0, 1); done(4, 0);
        tick();
        clr_in();
        check("simul_full", 16'(bus.sb_full), 16'h0);
        src(0, 4, 0); src(1, 6, 0);
        #1 check("simul_pend", 16'(bus.hz_stall), 16'h1);
        bus.id_rs_used[1] = 0;
        #1 check("simul_clr", 16'(bus.hz_stall), 16'h0);
        clr_in();
        issue(7, 0, 1);
        tick();
        clr_in();
        check("cnt4_full", 16'(bus.sb_full), 16'h1);

        // WAW on x9 and asynchronous reset mid-stall
        done(1, 0);
        tick();
        clr_in();
        issue(9, 0, 1);
        tick();
        clr_in();
        check("x9_full", 16'(bus.sb_full), 16'h1);
        issue(9, 0, 0);
        #1 check("waw_stall", 16'(bus.hz_stall), 16'h1);
        #1 rst_n = 1'b0;
        #1 check("rst_waw_stall", 16'(bus.hz_stall), 16'h0);
        check("rst_mid_full", 16'(bus.sb_full), 16'h0);
        tick();
        rst_n = 1'b1;
        clr_in();
        src(0, 9, 0); src(1, 5, 0);
        #1 check("post_rst_pend", 16'(bus.hz_stall), 16'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
